if_id_fetch_stage: RTL and testbench

- Instruction-fetch stage directly downstream of the program counter.
- Takes the current fetch address, issues one instruction-memory request at a time over a valid/ready handshake, and captures the returned word into the IF/ID pipeline register.
- Generates a fetch-busy stall back to the PC so the PC advances only when a request is accepted.
- Handles decode back-pressure (stall) and branch/jump redirect (flush) with discard of in-flight responses.

---
 rtl/riscvx_pkg.sv | 23 ++
 rtl/if_id_fetch_stage_if.sv | 39 +++
 rtl/fetch_hold_buf.sv | 56 +++++
 rtl/if_id_fetch_stage.sv | 249 ++++++++++++++++++++++++
 tb/tb_if_id_fetch_stage.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscvx_pkg.sv
// ----------------------------------------------------------------------------
// riscvx_pkg
// Definitions shared by the instruction-fetch slice of the core.
//   fetch_state_t : fetch FSM states (REQ, WAIT, HOLD)
//   XLEN_DEFAULT  : default address / instruction width
//   NOP_INSTR     : canonical bubble instruction, addi x0,x0,0
// ----------------------------------------------------------------------------
package riscvx_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // REQ  : request is presented to instruction memory
   // WAIT : one request is outstanding, waiting for its response
   // HOLD : response captured in the skid buffer while decode is stalled
   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/if_id_fetch_stage_if.sv
// ----------------------------------------------------------------------------
// if_id_fetch_stage_if
// Instruction-memory request/response channel between the fetch stage and
// the instruction memory.
//   imem_req_valid : request valid              (master -> slave)
//   imem_req_addr  : request address            (master -> slave)
//   imem_req_ready : memory accepts the request (slave  -> master)
//   imem_rsp_valid : response word valid        (slave  -> master)
//   imem_rsp_data  : instruction word           (slave  -> master)
// ----------------------------------------------------------------------------
interface if_id_fetch_stage_if #(
   parameter int XLEN = 32
);

   logic            imem_req_valid;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_req_ready;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;

   // Fetch-stage side of the channel
   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data
   );

   // Instruction-memory side of the channel
   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data
   );

endinterface

// File: rtl/fetch_hold_buf.sv
// ----------------------------------------------------------------------------
// fetch_hold_buf
// Single-entry skid register holding a fetched pc/instruction pair while
// decode is stalled.
//   clk, reset : clock, asynchronous active-high reset
//   i_load     : capture i_pc / i_instr and mark the entry valid
//   i_unload   : entry has been moved downstream, mark it invalid
//   i_clear    : discard the entry (redirect); wins over load and unload
//   i_pc       : address of the word being captured
//   i_instr    : instruction word being captured
//   o_valid    : entry holds a live instruction
//   o_pc       : stored address
//   o_instr    : stored instruction word
// ----------------------------------------------------------------------------
module fetch_hold_buf #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_load,
   input  logic            i_unload,
   input  logic            i_clear,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_instr,
   output logic            o_valid,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_instr
);

   logic            r_valid;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_instr;

   // Entry storage. A clear (redirect) must win so that a word fetched down
   // the wrong path can never be moved into IF/ID afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_pc    <= '0;
         r_instr <= '0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_pc    <= i_pc;
         r_instr <= i_instr;
      end else if (i_unload) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_pc    = r_pc;
   assign o_instr = r_instr;

endmodule

// File: rtl/if_id_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_id_fetch_stage
// Instruction-fetch stage between the program counter and decode. Issues one
// instruction-memory request at a time, captures the returned word into the
// IF/ID pipeline register, and stalls the PC until a request is accepted.
// Decode back-pressure parks a returned word in a one-entry skid buffer;
// a redirect (flush) empties IF/ID and discards any in-flight response.
//
// Ports
//   clk, reset  : clock, asynchronous active-high reset
//   pc          : current fetch address from the program counter
//   stall       : IF/ID hold request from hazard detection
//   flush       : branch/jump redirect, kills IF/ID and in-flight fetch
//   fetch_busy  : PC must hold while 1
//   imem        : instruction-memory channel (master modport)
//   id_valid    : IF/ID holds a live instruction
//   id_pc       : address of the instruction in IF/ID
//   id_instr    : instruction in IF/ID (NOP_INSTR when id_valid=0)
//
// Optional build macro FETCH_PERF_CNT_EN adds:
//   perf_fetched : words loaded into IF/ID (wraps at 2^32)
//   perf_dropped : memory responses discarded because of a flush
// ----------------------------------------------------------------------------
module if_id_fetch_stage
   import riscvx_pkg::*;
#(
   parameter int              XLEN      = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] NOP_INSTR = riscvx_pkg::NOP_INSTR
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [XLEN-1:0]     pc,
   input  logic                stall,
   input  logic                flush,
   output logic                fetch_busy,
   if_id_fetch_stage_if.master imem,
   output logic                id_valid,
   output logic [XLEN-1:0]     id_pc,
   output logic [XLEN-1:0]     id_instr
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]         perf_fetched,
   output logic [31:0]         perf_dropped
`endif
);

   fetch_state_t    r_state;
   fetch_state_t    w_nextState;
   logic            r_drop;
   logic            w_nextDrop;
   logic [XLEN-1:0] r_reqPc;

   logic            r_idValid;
   logic [XLEN-1:0] r_idPc;
   logic [XLEN-1:0] r_idInstr;

   logic            w_accept;
   logic            w_latchReq;
   logic            w_idKill;
   logic            w_idLoadRsp;
   logic            w_idLoadBuf;
   logic            w_idBubble;
   logic            w_bufLoad;
   logic            w_bufUnload;
   logic            w_bufClear;

   logic            w_bufValid;
   logic [XLEN-1:0] w_bufPc;
   logic [XLEN-1:0] w_bufInstr;

   // The request is suppressed while reset is held so memory never sees a
   // request from a stage that is still being initialised. The PC may only
   // advance on the exact cycle a request is accepted.
   assign imem.imem_req_valid = (r_state == REQ) && !reset;
   assign imem.imem_req_addr  = pc;
   assign w_accept            = imem.imem_req_valid && imem.imem_req_ready;
   assign fetch_busy          = !w_accept;

   // Next-state and datapath control. A flush overrides everything; if a
   // request is in flight when it arrives (already outstanding, or being
   // accepted this very cycle) the stale response is marked for discard.
   always_comb begin
      w_nextState = r_state;
      w_nextDrop  = r_drop;
      w_latchReq  = 1'b0;
      w_idKill    = 1'b0;
      w_idLoadRsp = 1'b0;
      w_idLoadBuf = 1'b0;
      w_idBubble  = 1'b0;
      w_bufLoad   = 1'b0;
      w_bufUnload = 1'b0;
      w_bufClear  = 1'b0;

      if (flush) begin
         w_idKill    = 1'b1;
         w_bufClear  = 1'b1;
         w_nextState = REQ;
         case (r_state)
            REQ: begin
               if (w_accept) begin
                  w_nextState = WAIT;
                  w_nextDrop  = 1'b1;
               end
            end
            WAIT: begin
               if (imem.imem_rsp_valid) begin
                  w_nextDrop = 1'b0;
               end else begin
                  w_nextState = WAIT;
                  w_nextDrop  = 1'b1;
               end
            end
            default: begin
            end
         endcase
      end else begin
         case (r_state)
            REQ: begin
               if (!stall) begin
                  w_idBubble = 1'b1;
               end
               if (w_accept) begin
                  w_latchReq  = 1'b1;
                  w_nextState = WAIT;
               end
            end
            WAIT: begin
               if (imem.imem_rsp_valid) begin
                  w_nextState = REQ;
                  if (r_drop) begin
                     w_nextDrop = 1'b0;
                     if (!stall) begin
                        w_idBubble = 1'b1;
                     end
                  end else if (!stall) begin
                     w_idLoadRsp = 1'b1;
                  end else begin
                     w_bufLoad   = 1'b1;
                     w_nextState = HOLD;
                  end
               end else if (!stall) begin
                  w_idBubble = 1'b1;
               end
            end
            HOLD: begin
               if (!stall) begin
                  w_nextState = REQ;
                  if (w_bufValid) begin
                     w_idLoadBuf = 1'b1;
                     w_bufUnload = 1'b1;
                  end
               end
            end
            default: begin
               w_nextState = REQ;
            end
         endcase
      end
   end

   // FSM state, drop flag and the address of the outstanding request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= REQ;
         r_drop  <= 1'b0;
         r_reqPc <= '0;
      end else begin
         r_state <= w_nextState;
         r_drop  <= w_nextDrop;
         if (w_latchReq) begin
            r_reqPc <= pc;
         end
      end
   end

   // IF/ID pipeline register. The instruction field is forced to NOP
   // whenever the register empties, so decode always sees a harmless word
   // when id_valid is low. id_pc is left alone on a bubble.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idValid <= 1'b0;
         r_idPc    <= '0;
         r_idInstr <= NOP_INSTR;
      end else if (w_idKill) begin
         r_idValid <= 1'b0;
         r_idInstr <= NOP_INSTR;
      end else if (w_idLoadRsp) begin
         r_idValid <= 1'b1;
         r_idPc    <= r_reqPc;
         r_idInstr <= imem.imem_rsp_data;
      end else if (w_idLoadBuf) begin
         r_idValid <= 1'b1;
         r_idPc    <= w_bufPc;
         r_idInstr <= w_bufInstr;
      end else if (w_idBubble) begin
         r_idValid <= 1'b0;
         r_idInstr <= NOP_INSTR;
      end
   end

   assign id_valid = r_idValid;
   assign id_pc    = r_idPc;
   assign id_instr = r_idInstr;

   // Skid buffer for a word that returns while decode is stalled
   fetch_hold_buf #(
      .XLEN (XLEN)
   ) u_holdBuf (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_bufLoad),
      .i_unload (w_bufUnload),
      .i_clear  (w_bufClear),
      .i_pc     (r_reqPc),
      .i_instr  (imem.imem_rsp_data),
      .o_valid  (w_bufValid),
      .o_pc     (w_bufPc),
      .o_instr  (w_bufInstr)
   );

`ifdef FETCH_PERF_CNT_EN
   logic        w_rspDropped;
   logic [31:0] r_perfFetched;
   logic [31:0] r_perfDropped;

   // A memory response is thrown away either because it was already marked
   // stale or because a redirect lands in the same cycle it returns.
   assign w_rspDropped = (r_state == WAIT) && imem.imem_rsp_valid && (flush || r_drop);

   // Free-running event counters; both wrap naturally at 2^32.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_perfFetched <= '0;
         r_perfDropped <= '0;
      end else begin
         if (w_idLoadRsp || w_idLoadBuf) begin
            r_perfFetched <= r_perfFetched + 32'd1;
         end
         if (w_rspDropped) begin
            r_perfDropped <= r_perfDropped + 32'd1;
         end
      end
   end

   assign perf_fetched = r_perfFetched;
   assign perf_dropped = r_perfDropped;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_if_id_fetch_stage
// Self-checking bench for if_id_fetch_stage. Each task scripts the memory
// and pipeline-control inputs cycle by cycle. Words expected to reach IF/ID
// are queued when their response is driven; a negedge monitor pops and
// compares them whenever a fresh instruction appears in IF/ID.
// ----------------------------------------------------------------------------
module tb_if_id_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [31:0] pc;
   logic        stall;
   logic        flush;
   logic        fetch_busy;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_dropped;
`endif

   int   nTests;
   int   nFail;
   int   expFetched;
   int   expDropped;
   exp_t sbQ[$];
   logic prevValid;
   logic prevConsumed;

   if_id_fetch_stage_if #(.XLEN(32)) imem ();

   if_id_fetch_stage #(
      .XLEN      (32),
      .NOP_INSTR (32'h0000_0013)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pc           (pc),
      .stall        (stall),
      .flush        (flush),
      .fetch_busy   (fetch_busy),
      .imem         (imem),
      .id_valid     (id_valid),
      .id_pc        (id_pc),
      .id_instr     (id_instr)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_dropped (perf_dropped)
`endif
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge, where inputs are driven
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Queue an instruction that must later appear in IF/ID
   task automatic push(input logic [31:0] p, input logic [31:0] w);
      exp_t e;
      e.pc    = p;
      e.instr = w;
      sbQ.push_back(e);
      expFetched++;
   endtask

   // Scoreboard monitor: an instruction is fresh when IF/ID is valid and the
   // previous contents were absent or consumed (no stall, or killed by flush)
   always @(negedge clk) begin
      if (!reset) begin
         if (!id_valid) begin
            nTests++;
            if (id_instr !== NOP) begin
               nFail++;
               $display("[TB] FAIL mon_nop: id_instr got %h expected %h", id_instr, NOP);
            end
         end
         if (id_valid && (!prevValid || prevConsumed)) begin
            nTests++;
            if (sbQ.size() == 0) begin
               nFail++;
               $display("[TB] FAIL mon_unexpected: got pc %h instr %h expected none", id_pc, id_instr);
            end else begin
               exp_t e;
               e = sbQ.pop_front();
               if (id_pc !== e.pc || id_instr !== e.instr) begin
                  nFail++;
                  $display("[TB] FAIL mon_word: got pc %h instr %h expected pc %h instr %h",
                           id_pc, id_instr, e.pc, e.instr);
               end
            end
         end
      end
      prevValid    = id_valid;
      prevConsumed = id_valid && (!stall || flush);
   end

   task automatic test_reset();
      @(negedge clk);
      nTests++; if (id_valid !== 1'b0) begin nFail++; $display("[TB] FAIL rst_valid: got %b expected 0", id_valid); end
      nTests++; if (id_pc !== 32'h0) begin nFail++; $display("[TB] FAIL rst_pc: got %h expected 0", id_pc); end
      nTests++; if (id_instr !== NOP) begin nFail++; $display("[TB] FAIL rst_instr: got %h expected %h", id_instr, NOP); end
      nTests++; if (imem.imem_req_valid !== 1'b0) begin nFail++; $display("[TB] FAIL rst_reqv: got %b expected 0", imem.imem_req_valid); end
      nTests++; if (fetch_busy !== 1'b1) begin nFail++; $display("[TB] FAIL rst_busy: got %b expected 1", fetch_busy); end
      cyc();
      reset = 1'b0;
   endtask

   task automatic test_basic();
      pc = 32'h0; stall = 1'b0; imem.imem_req_ready = 1'b1;
      @(negedge clk);
      nTests++; if (imem.imem_req_valid !== 1'b1) begin nFail++; $display("[TB] FAIL basic_reqv: got %b expected 1", imem.imem_req_valid); end
      nTests++; if (imem.imem_req_addr !== 32'h0) begin nFail++; $display("[TB] FAIL basic_addr: got %h expected 0", imem.imem_req_addr); end
      nTests++; if (fetch_busy !== 1'b0) begin nFail++; $display("[TB] FAIL basic_busy_acc: got %b expected 0", fetch_busy); end
      cyc();
      pc = 32'h4; imem.imem_req_ready = 1'b0;
      imem.imem_rsp_valid = 1'b1; imem.imem_rsp_data = 32'h0050_0093;
      push(32'h0, 32'h0050_0093);
      @(negedge clk);
      nTests++; if (fetch_busy !== 1'b1) begin nFail++; $display("[TB] FAIL basic_busy_wait: got %b expected 1", fetch_busy); end
      nTests++; if (imem.imem_req_valid !== 1'b0) begin nFail++; $display("[TB] FAIL basic_reqv_wait: got %b expected 0", imem.imem_req_valid); end
      nTests++; if (id_valid !== 1'b0) begin nFail++; $display("[TB] FAIL basic_early: got %b expected 0", id_valid); end
      cyc();
      imem.imem_rsp_valid = 1'b0;
      @(negedge clk);
      nTests++; if (id_valid !== 1'b1) begin nFail++; $display("[TB] FAIL basic_valid: got %b expected 1", id_valid); end
      nTests++; if (id_pc !== 32'h0) begin nFail++; $display("[TB] FAIL basic_pc: got %h expected 0", id_pc); end
      nTests++; if (id_instr !== 32'h0050_0093) begin nFail++; $display("[TB] FAIL basic_instr: got %h expected 00500093", id_instr); end
      cyc();
      @(negedge clk);
      nTests++; if (id_valid !== 1'b0) begin nFail++; $display("[TB] FAIL basic_bubble: got %b expected 0", id_valid); end
   endtask

   task automatic test_ready_low();
      cyc();
      pc = 32'h10; imem.imem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         nTests++; if (imem.imem_req_valid !== 1'b1) begin nFail++; $display("[TB] FAIL rdy_reqv: got %b expected 1", imem.imem_req_valid); end
         nTests++; if (imem.imem_req_addr !== 32'h10) begin nFail++; $display("[TB] FAIL rdy_addr: got %h expected 10", imem.imem_req_addr); end
         nTests++; if (fetch_busy !== 1'b1) begin nFail++; $display("[TB] FAIL rdy_busy: got %b expected 1", fetch_busy); end
         cyc();
      end
      imem.imem_req_ready = 1'b1;
      @(negedge clk);
      nTests++; if (fetch_busy !== 1'b0) begin nFail++; $display("[TB] FAIL rdy_accept: got %b expected 0", fetch_busy); end
      cyc();
      imem.imem_req_ready = 1'b0; pc = 32'h14;
      @(negedge clk);
      nTests++; if (imem.imem_req_valid !== 1'b0) begin nFail++; $display("[TB] FAIL rdy_single: got %b expected 0", imem.imem_req_valid); end
      cyc();
      imem.imem_rsp_valid = 1'b1; imem.imem_rsp_data = 32'h0000_0073;
      push(32'h10, 32'h0000_0073);
      cyc();
      imem.imem_rsp_valid = 1'b0;
      @(negedge clk);
      nTests++; if (id_pc !== 32'h10) begin nFail++; $display("[TB] FAIL rdy_pc: got %h expected 10", id_pc); end
      cyc();
   endtask

   task automatic test_stall_hold();
      pc = 32'h20; imem.imem_req_ready = 1'b1;
      cyc();
      imem.imem_req_ready = 1'b0; pc = 32'h24;
      imem.imem_rsp_valid = 1'b1; imem.imem_rsp_data = 32'h0020_0113;
      push(32'h20, 32'h0020_0113);
      cyc();
      imem.imem_rsp_valid = 1'b0; stall = 1'b1; imem.imem_req_ready = 1'b1;
      cyc();
      imem.imem_req_ready = 1'b0; pc = 32'h28;
      imem.imem_rsp_valid = 1'b1; imem.imem_rsp_data = 32'h00A0_0113;
      push(32'h24, 32'h00A0_0113);
      cyc();
      imem.imem_rsp_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         nTests++; if (id_pc !== 32'h20 || id_instr !== 32'h0020_0113 || id_valid !== 1'b1) begin
            nFail++; $display("[TB] FAIL stall_keep: got v%b %h/%h expected v1 20/00200113", id_valid, id_pc, id_instr);
         end
         nTests++; if (imem.imem_req_valid !== 1'b0) begin nFail++; $display("[TB] FAIL stall_noreq: got %b expected 0", imem.imem_req_valid); end
         cyc();
      end
      stall = 1'b0;
      @(negedge clk);
      nTests++; if (id_pc !== 32'h20) begin nFail++; $display("[TB] FAIL stall_last: got %h expected 20", id_pc); end
      cyc();
      @(negedge clk);
      nTests++; if (id_pc !== 32'h24 || id_instr !== 32'h00A0_0113 || id_valid !== 1'b1) begin
         nFail++; $display("[TB] FAIL stall_release: got v%b %h/%h expected v1 24/00a00113", id_valid, id_pc, id_instr);
      end
      nTests++; if (imem.imem_req_valid !== 1'b1) begin nFail++; $display("[TB] FAIL stall_req: got %b expected 1", imem.imem_req_valid); end
      cyc();
      @(negedge clk);
      nTests++; if (id_valid !== 1'b0) begin nFail++; $display("[TB] FAIL stall_bubble: got %b expected 0", id_valid); end
      cyc();
   endtask

   task automatic test_flush_corner();
      pc = 32'h50; imem.imem_req_ready = 1'b1; flush = 1'b1;
      @(negedge clk);
      nTests++; if (fetch_busy !== 1'b0) begin nFail++; $display("[TB] FAIL fc_accept: got %b expected 0", fetch_busy); end
      cyc();
      flush = 1'b0; imem.imem_req_ready = 1'b0;
      imem.imem_rsp_valid = 1'b1; imem.imem_rsp_data = 32'hBADC_0DE0;
      expDropped++;
      @(negedge clk);
      nTests++; if (imem.imem_req_valid !== 1'b0) begin nFail++; $display("[TB] FAIL fc_inflight: got %b expected 0", imem.imem_req_valid); end
      cyc();
      imem.imem_rsp_valid = 1'b0;
      @(negedge clk);
      nTests++; if (id_valid !== 1'b0) begin nFail++; $display("[TB] FAIL fc_drop: got %b expected 0", id_valid); end
      nTests++; if (imem.imem_req_valid !== 1'b1) begin nFail++; $display("[TB] FAIL fc_req: got %b expected 1", imem.imem_req_valid); end
      pc = 32'h60; imem.imem_req_ready = 1'b1;
      cyc();
      imem.imem_req_ready = 1'b0; flush = 1'b1;
      imem.imem_rsp_valid = 1'b1; imem.imem_rsp_data = 32'hCAFE_F00D;
      expDropped++;
      cyc();
      flush = 1'b0; imem.imem_rsp_valid = 1'b0;
      @(negedge clk);
      nTests++; if (id_valid !== 1'b0) begin nFail++; $display("[TB] FAIL fc_same: got %b expected 0", id_valid); end
      nTests++; if (imem.imem_req_valid !== 1'b1) begin nFail++; $display("[TB] FAIL fc_same_req: got %b expected 1", imem.imem_req_valid); end
      cyc();
   endtask

   task automatic test_flush_wait();
      pc = 32'h30; imem.imem_req_ready = 1'b1;
      cyc();
      imem.imem_req_ready = 1'b0; pc = 32'h34;
      imem.imem_rsp_valid = 1'b1; imem.imem_rsp_data = 32'h0040_0213;
      push(32'h30, 32'h0040_0213);
      cyc();
      imem.imem_rsp_valid = 1'b0; stall = 1'b1; imem.imem_req_ready = 1'b1;
      cyc();
      imem.imem_req_ready = 1'b0; pc = 32'h38; flush = 1'b1;
      @(negedge clk);
      nTests++; if (id_valid !== 1'b1) begin nFail++; $display("[TB] FAIL fw_pre: got %b expected 1", id_valid); end
      cyc();
      flush = 1'b0; stall = 1'b0; pc = 32'h80;
      @(negedge clk);
      nTests++; if (id_valid !== 1'b0) begin nFail++; $display("[TB] FAIL fw_kill: got %b expected 0", id_valid); end
      nTests++; if (imem.imem_req_valid !== 1'b0) begin nFail++; $display("[TB] FAIL fw_waitdrop: got %b expected 0", imem.imem_req_valid); end
      cyc();
      imem.imem_rsp_valid = 1'b1; imem.imem_rsp_data = 32'hDEAD_BEEF;
      expDropped++;
      @(negedge clk);
      nTests++; if (fetch_busy !== 1'b1) begin nFail++; $display("[TB] FAIL fw_busy: got %b expected 1", fetch_busy); end
      cyc();
      imem.imem_rsp_valid = 1'b0; imem.imem_req_ready = 1'b1;
      @(negedge clk);
      nTests++; if (id_instr !== NOP || id_valid !== 1'b0) begin nFail++; $display("[TB] FAIL fw_discard: got v%b %h expected v0 %h", id_valid, id_instr, NOP); end
      nTests++; if (imem.imem_req_addr !== 32'h80 || fetch_busy !== 1'b0) begin
         nFail++; $display("[TB] FAIL fw_redirect: got addr %h busy %b expected 80 0", imem.imem_req_addr, fetch_busy);
      end
      cyc();
      imem.imem_req_ready = 1'b0; pc = 32'h84;
      imem.imem_rsp_valid = 1'b1; imem.imem_rsp_data = 32'h0030_0193;
      push(32'h80, 32'h0030_0193);
      cyc();
      imem.imem_rsp_valid = 1'b0;
      @(negedge clk);
      nTests++; if (id_pc !== 32'h80 || id_instr !== 32'h0030_0193) begin
         nFail++; $display("[TB] FAIL fw_new: got %h/%h expected 80/00300193", id_pc, id_instr);
      end
      cyc();
   endtask

   task automatic test_flush_stall_hold();
      pc = 32'h40; imem.imem_req_ready = 1'b1;
      cyc();
      imem.imem_req_ready = 1'b0; pc = 32'h44;
      imem.imem_rsp_valid = 1'b1; imem.imem_rsp_data = 32'h0050_0293;
      push(32'h40, 32'h0050_0293);
      cyc();
      imem.imem_rsp_valid = 1'b0; stall = 1'b1; imem.imem_req_ready = 1'b1;
      cyc();
      imem.imem_req_ready = 1'b0; pc = 32'h48;
      imem.imem_rsp_valid = 1'b1; imem.imem_rsp_data = 32'h0060_0313;
      cyc();
      imem.imem_rsp_valid = 1'b0; flush = 1'b1;
      @(negedge clk);
      nTests++; if (id_valid !== 1'b1 || id_pc !== 32'h40 || imem.imem_req_valid !== 1'b0) begin
         nFail++; $display("[TB] FAIL fsh_hold: got v%b pc %h req %b expected v1 40 0", id_valid, id_pc, imem.imem_req_valid);
      end
      cyc();
      flush = 1'b0; stall = 1'b0; pc = 32'hC0;
      @(negedge clk);
      nTests++; if (id_valid !== 1'b0 || id_instr !== NOP) begin nFail++; $display("[TB] FAIL fsh_kill: got v%b %h expected v0 %h", id_valid, id_instr, NOP); end
      nTests++; if (imem.imem_req_valid !== 1'b1) begin nFail++; $display("[TB] FAIL fsh_req: got %b expected 1", imem.imem_req_valid); end
      cyc();
      @(negedge clk);
      nTests++; if (id_valid !== 1'b0) begin nFail++; $display("[TB] FAIL fsh_nobuf: got %b expected 0", id_valid); end
      cyc();
   endtask

   task automatic test_reset_mid();
`ifdef FETCH_PERF_CNT_EN
      @(negedge clk);
      nTests++; if (perf_fetched !== 32'(expFetched)) begin nFail++; $display("[TB] FAIL perf_fetched: got %0d expected %0d", perf_fetched, expFetched); end
      nTests++; if (perf_dropped !== 32'(expDropped)) begin nFail++; $display("[TB] FAIL perf_dropped: got %0d expected %0d", perf_dropped, expDropped); end
      cyc();
`endif
      pc = 32'h90; imem.imem_req_ready = 1'b1;
      cyc();
      imem.imem_req_ready = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      nTests++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== NOP) begin
         nFail++; $display("[TB] FAIL rm_regs: got v%b %h/%h expected v0 0/%h", id_valid, id_pc, id_instr, NOP);
      end
      nTests++; if (imem.imem_req_valid !== 1'b0) begin nFail++; $display("[TB] FAIL rm_reqv: got %b expected 0", imem.imem_req_valid); end
`ifdef FETCH_PERF_CNT_EN
      nTests++; if (perf_fetched !== 32'h0 || perf_dropped !== 32'h0) begin
         nFail++; $display("[TB] FAIL rm_perf: got %0d/%0d expected 0/0", perf_fetched, perf_dropped);
      end
`endif
      cyc();
      reset = 1'b0;
      imem.imem_rsp_valid = 1'b1; imem.imem_rsp_data = 32'h1111_1111;
      @(negedge clk);
      nTests++; if (imem.imem_req_valid !== 1'b1) begin nFail++; $display("[TB] FAIL rm_req: got %b expected 1", imem.imem_req_valid); end
      cyc();
      imem.imem_rsp_valid = 1'b0;
      @(negedge clk);
      nTests++; if (id_valid !== 1'b0 || id_instr !== NOP) begin nFail++; $display("[TB] FAIL rm_stale: got v%b %h expected v0 %h", id_valid, id_instr, NOP); end
      cyc();
   endtask

   // Test sequence
   initial begin
      nTests = 0; nFail = 0; expFetched = 0; expDropped = 0;
      prevValid = 1'b0; prevConsumed = 1'b0;
      reset = 1'b1; pc = '0; stall = 1'b0; flush = 1'b0;
      imem.imem_req_ready = 1'b0; imem.imem_rsp_valid = 1'b0; imem.imem_rsp_data = '0;
      test_reset();
      test_basic();
      test_ready_low();
      test_stall_hold();
      test_flush_corner();
      test_flush_wait();
      test_flush_stall_hold();
      test_reset_mid();
      nTests++;
      if (sbQ.size() != 0) begin
         nFail++; $display("[TB] FAIL sb_empty: got %0d pending expected 0", sbQ.size());
      end
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
